// File: rtl/spi_master_core.sv
// SPI master: one DATA_W-bit frame per accepted request, with CPOL/CPHA captured per frame
// and a fixed SCLK half-period of CLK_DIV system clocks.
module spi_master_core #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 2,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              cpol,
    input  logic              cpha,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned TW       = $clog2(2 * DATA_W + 1);
    localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [TW-1:0] TOG_LAST = TW'(2 * DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t            state_q;
    logic [7:0]        div_q;
    logic [TW-1:0]     tog_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              tx_ready_q;
    logic              busy_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              rx_valid_q;
    logic [DATA_W-1:0] rx_data_q;

    logic [DATA_W-1:0] tx_sh_d;
    logic [DATA_W-1:0] rx_sh_d;
    logic              first_bit_d;
    logic              next_bit_d;
    logic              div_done;
    logic [TW-1:0]     tog_n;
    logic              odd_tog;
    logic              do_sample;
    logic              do_advance;

    always_comb begin
        div_done = (div_q == DIV_LAST);
        tog_n    = tog_q + 1'b1;
        odd_tog  = tog_n[0];
        // cpha=0 samples on odd toggles, cpha=1 on even ones; the other parity shifts mosi
        do_sample  = (odd_tog != cpha_q);
        do_advance = (odd_tog == cpha_q) && (tog_n != TOG_LAST) && (tog_n != TW'(1));
        if (LSB_FIRST) begin
            first_bit_d = tx_data[0];
            next_bit_d  = tx_sh_q[1];
            tx_sh_d     = tx_sh_q >> 1;
            rx_sh_d     = {miso, rx_sh_q[DATA_W-1:1]};
        end else begin
            first_bit_d = tx_data[DATA_W-1];
            next_bit_d  = tx_sh_q[DATA_W-2];
            tx_sh_d     = tx_sh_q << 1;
            rx_sh_d     = {rx_sh_q[DATA_W-2:0], miso};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= '0;
            tog_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    if (tx_valid) begin
                        tx_sh_q    <= tx_data;
                        rx_sh_q    <= '0;
                        cpol_q     <= cpol;
                        cpha_q     <= cpha;
                        mosi_q     <= first_bit_d;
                        busy_q     <= 1'b1;
                        cs_n_q     <= 1'b0;
                        tx_ready_q <= 1'b0;
                        div_q      <= '0;
                        tog_q      <= '0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_done) begin
                        div_q   <= '0;
                        state_q <= XFER;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                XFER: begin
                    if (div_done) begin
                        div_q  <= '0;
                        tog_q  <= tog_n;
                        sclk_q <= ~sclk_q;
                        if (do_sample) begin
                            rx_sh_q <= rx_sh_d;
                        end
                        if (do_advance) begin
                            tx_sh_q <= tx_sh_d;
                            mosi_q  <= next_bit_d;
                        end
                        if (tog_n == TOG_LAST) begin
                            state_q <= HOLD;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (div_done) begin
                        div_q      <= '0;
                        cs_n_q     <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= GAP;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                GAP: begin
                    if (div_done) begin
                        div_q      <= '0;
                        busy_q     <= 1'b0;
                        tx_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Scoreboard bench: two configurations of spi_master_core observed by an SPI-slave-view monitor.
module tb_spi_master_core;

    typedef struct {
        logic [31:0] d;
        bit          pol;
        bit          pha;
        bit          loop;
        bit          tie;
        bit          b2b;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // instance A: DATA_W=8, CLK_DIV=2, MSB first
    logic [7:0]  a_data, a_rx_data;
    logic        a_valid, a_ready, a_cpol, a_cpha, a_rx_valid, a_busy, a_cs_n, a_sclk, a_mosi, a_miso;
    logic        a_loop, a_tie;
    // instance B: DATA_W=16, CLK_DIV=1, LSB first
    logic [15:0] b_data, b_rx_data;
    logic        b_valid, b_ready, b_cpol, b_cpha, b_rx_valid, b_busy, b_cs_n, b_sclk, b_mosi, b_miso;
    logic        b_loop, b_tie;

    assign a_miso = a_loop ? a_mosi : a_tie;
    assign b_miso = b_loop ? b_mosi : b_tie;

    spi_master_core #(.DATA_W(8), .CLK_DIV(2), .LSB_FIRST(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
        .cpol(a_cpol), .cpha(a_cpha), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .busy(a_busy),
        .cs_n(a_cs_n), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso)
    );

    spi_master_core #(.DATA_W(16), .CLK_DIV(1), .LSB_FIRST(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .cpol(b_cpol), .cpha(b_cpha), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .busy(b_busy),
        .cs_n(b_cs_n), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso)
    );

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    frame_t qa[$];
    frame_t qb[$];
    bit     b2b_flag[2];

    // slave-view monitor state, indexed by instance
    logic        prev_cs[2], prev_sclk[2], prev_rdy[2], in_frame[2];
    int          cs_lo[2], cs_hi[2], rdy_lo[2], nbits[2], toggles[2];
    logic [31:0] word[2], last_rx[2];
    frame_t      cur[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] width_mask(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // what a slave with the given miso wiring shifts back to the master
    function automatic logic [31:0] expected_rx(input frame_t f, input int w);
        if (f.loop) return f.d & width_mask(w);
        return f.tie ? width_mask(w) : 32'd0;
    endfunction

    always @(posedge clk) begin
        if (rst_n && a_valid && a_ready)
            qa.push_back('{d: 32'(a_data), pol: a_cpol, pha: a_cpha, loop: a_loop, tie: a_tie, b2b: b2b_flag[0]});
        if (rst_n && b_valid && b_ready)
            qb.push_back('{d: 32'(b_data), pol: b_cpol, pha: b_cpha, loop: b_loop, tie: b_tie, b2b: b2b_flag[1]});
    end

    task automatic mon(input int i, input int w, input int div, input bit lsb,
                       input logic rst, input logic cs, input logic sck, input logic mo,
                       input logic rxv, input logic [31:0] rxd, input logic rdy);
        string p;
        bit    rise;
        bit    leading;
        int    qsz;
        p = (i == 0) ? "A." : "B.";
        if (!rst) begin
            in_frame[i] = 1'b0;
            prev_cs[i] = cs; prev_sclk[i] = sck; prev_rdy[i] = rdy;
            cs_lo[i] = 0; cs_hi[i] = 0; rdy_lo[i] = 0; nbits[i] = 0; toggles[i] = 0;
            last_rx[i] = '0;
            return;
        end
        rise = !prev_cs[i] && cs;
        if (rise && in_frame[i]) begin
            check({p, "cs_low_cycles"}, 32'(cs_lo[i]), 32'(div * (2 * w + 2)));
            check({p, "rx_valid_at_cs_rise"}, 32'(rxv), 32'd1);
            check({p, "rx_data"}, rxd, expected_rx(cur[i], w));
            check({p, "mosi_bits"}, word[i], cur[i].d & width_mask(w));
            check({p, "sample_edges"}, 32'(nbits[i]), 32'(w));
            check({p, "sclk_toggles"}, 32'(toggles[i]), 32'(2 * w));
            last_rx[i] = expected_rx(cur[i], w);
            in_frame[i] = 1'b0;
        end else if (rxv) begin
            check({p, "stray_rx_valid"}, 32'(rxv), 32'd0);
        end
        if (rise) cs_hi[i] = 0;
        if (prev_cs[i] && !cs) begin
            qsz = (i == 0) ? qa.size() : qb.size();
            if (qsz == 0) begin
                check({p, "frame_expected"}, 32'(qsz), 32'd1);
            end else begin
                cur[i] = (i == 0) ? qa.pop_front() : qb.pop_front();
                in_frame[i] = 1'b1;
                check({p, "sclk_idle_level"}, 32'(sck), 32'(cur[i].pol));
                check({p, "first_mosi_bit"}, 32'(mo), 32'(lsb ? cur[i].d[0] : cur[i].d[w-1]));
                if (cur[i].b2b) check({p, "cs_high_gap"}, 32'(cs_hi[i]), 32'(div + 1));
            end
            cs_lo[i] = 0; nbits[i] = 0; toggles[i] = 0; word[i] = '0;
        end
        if (!cs) begin
            cs_lo[i]++;
            if (in_frame[i] && !prev_cs[i] && sck != prev_sclk[i]) begin
                toggles[i]++;
                leading = (prev_sclk[i] == cur[i].pol);
                // mode 0/2 slaves sample on the leading edge, mode 1/3 on the trailing edge
                if (leading != cur[i].pha) begin
                    if (nbits[i] < w) word[i][lsb ? nbits[i] : (w - 1 - nbits[i])] = mo;
                    nbits[i]++;
                end
            end
        end else begin
            cs_hi[i]++;
        end
        if (prev_rdy[i] && !rdy) rdy_lo[i] = 0;
        if (!prev_rdy[i] && rdy) check({p, "tx_ready_low_cycles"}, 32'(rdy_lo[i]), 32'(div * (2 * w + 3)));
        if (!rdy) rdy_lo[i]++;
        prev_cs[i] = cs; prev_sclk[i] = sck; prev_rdy[i] = rdy;
    endtask

    always @(negedge clk) begin
        mon(0, 8, 2, 1'b0, rst_n, a_cs_n, a_sclk, a_mosi, a_rx_valid, 32'(a_rx_data), a_ready);
        mon(1, 16, 1, 1'b1, rst_n, b_cs_n, b_sclk, b_mosi, b_rx_valid, 32'(b_rx_data), b_ready);
    end

    task automatic set_inputs(input int sel, input logic [31:0] d, input bit pol, input bit pha);
        if (sel == 0) begin a_data = d[7:0];  a_cpol = pol; a_cpha = pha; a_valid = 1'b1; end
        else          begin b_data = d[15:0]; b_cpol = pol; b_cpha = pha; b_valid = 1'b1; end
    endtask

    task automatic wait_accept(input int sel);
        int n = 0;
        while (!((sel == 0) ? a_ready : b_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        @(negedge clk);
    endtask

    // called just after a negedge; returns at the negedge following acceptance
    task automatic start(input int sel, input logic [31:0] d, input bit pol, input bit pha);
        set_inputs(sel, d, pol, pha);
        wait_accept(sel);
        if (sel == 0) a_valid = 1'b0; else b_valid = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while (((sel == 0) ? a_busy : b_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("done_timeout", 32'(n), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        a_data = '0; a_valid = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_loop = 1'b1; a_tie = 1'b0;
        b_data = '0; b_valid = 1'b0; b_cpol = 1'b0; b_cpha = 1'b0; b_loop = 1'b1; b_tie = 1'b0;
        b2b_flag[0] = 1'b0; b2b_flag[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("A.rst_cs_n", 32'(a_cs_n), 32'd1);
        check("A.rst_sclk", 32'(a_sclk), 32'd0);
        check("A.rst_mosi", 32'(a_mosi), 32'd0);
        check("A.rst_rx_data", 32'(a_rx_data), 32'd0);
        check("A.rst_rx_valid", 32'(a_rx_valid), 32'd0);
        check("A.rst_busy", 32'(a_busy), 32'd0);
        check("A.rst_tx_ready", 32'(a_ready), 32'd1);
        check("B.rst_cs_n", 32'(b_cs_n), 32'd1);
        check("B.rst_rx_data", 32'(b_rx_data), 32'd0);
        check("B.rst_tx_ready", 32'(b_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // mode 0 loopback 0xA5
        a_loop = 1'b1;
        start(0, 32'hA5, 1'b0, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);
        check("A.rx_hold_a5", 32'(a_rx_data), 32'hA5);

        // mode 3, miso tied high, idle level follows cpol
        a_loop = 1'b0; a_tie = 1'b1; a_cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("A.sclk_idle_live_cpol", 32'(a_sclk), 32'd1);
        start(0, 32'h3C, 1'b1, 1'b1);
        wait_idle(0);

        for (int k = 0; k < 6; k++) begin
            a_loop = 1'($urandom_range(0, 1));
            a_tie  = 1'($urandom_range(0, 1));
            start(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle(0);
            check("A.rx_hold", 32'(a_rx_data), last_rx[0]);
        end

        // mid-frame input disturbance must not alter the frame in flight
        a_loop = 1'b1;
        start(0, 32'h5A, 1'b0, 1'b1);
        repeat (8) @(negedge clk);
        a_cpol = 1'b1; a_cpha = 1'b0; a_data = 8'hFF; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        wait_idle(0);
        check("A.no_second_accept", 32'(qa.size()), 32'd0);
        a_cpol = 1'b0;
        @(negedge clk);

        // reset mid-frame: abort immediately, accept on first cycle after release
        start(0, 32'hC3, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("A.abort_cs_n", 32'(a_cs_n), 32'd1);
        check("A.abort_rx_valid", 32'(a_rx_valid), 32'd0);
        check("A.abort_busy", 32'(a_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("A.ready_after_reset", 32'(a_ready), 32'd1);
        start(0, 32'h96, 1'b0, 1'b0);
        check("A.accept_first_cycle", 32'(a_busy), 32'd1);
        wait_idle(0);
        check("A.rx_after_reset", 32'(a_rx_data), 32'h96);

        // 16-bit LSB-first loopback
        b_loop = 1'b1;
        start(1, 32'h8001, 1'b0, 1'b0);
        wait_idle(1);
        check("B.rx_8001", 32'(b_rx_data), 32'h8001);

        // back-to-back with tx_valid held high
        set_inputs(1, 32'h0011, 1'b0, 1'b0);
        wait_accept(1);
        b_data = 16'h0022;
        b2b_flag[1] = 1'b1;
        wait_accept(1);
        b_valid = 1'b0;
        b2b_flag[1] = 1'b0;
        wait_idle(1);
        check("B.rx_b2b_last", 32'(b_rx_data), 32'h0022);

        for (int k = 0; k < 4; k++) begin
            b_loop = 1'($urandom_range(0, 1));
            b_tie  = 1'($urandom_range(0, 1));
            start(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_idle(1);
            check("B.rx_hold", 32'(b_rx_data), last_rx[1]);
        end

        check("A.frames_pending", 32'(qa.size()), 32'd0);
        check("B.frames_pending", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 Parameter DATA_W, default 8, frame width in bits; legal range 4..32.
REQ-002 Parameter CLK_DIV, default 2, SCLK half-period in clk cycles; legal range 1..255.
REQ-003 Parameter LSB_FIRST, default 0, bit order: 0 = MSB first, 1 = LSB first.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tx_data  input  DATA_W  frame to transmit, captured on acceptance.
REQ-007 tx_valid  input  1  request to start a frame.
REQ-008 tx_ready  output  1  block can accept a frame this cycle.
REQ-009 cpol  input  1  SCLK idle level, captured on acceptance.
REQ-010 cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; captured on acceptance.
REQ-011 rx_data  output  DATA_W  last completed received frame.
REQ-012 rx_valid  output  1  one-cycle pulse marking a new rx_data.
REQ-013 busy  output  1  high from acceptance until return to IDLE.
REQ-014 cs_n  output  1  active-low slave select.
REQ-015 sclk  output  1  serial clock.
REQ-016 mosi  output  1  serial data out.
REQ-017 miso  input  1  serial data in; sampled directly with no synchroniser.

Function
REQ-018 The state machine SHALL have the states IDLE, SETUP, XFER, HOLD and GAP; all outputs SHALL be registered.
REQ-019 tx_ready SHALL be 1 only in IDLE; acceptance SHALL be tx_valid && tx_ready on a clk edge.
REQ-020 On acceptance: capture tx_data, cpol and cpha; set busy=1 and cs_n=0; load the first bit onto mosi; enter SETUP.
- LSB_FIRST=0: first bit is tx_data[DATA_W-1].
- LSB_FIRST=1: first bit is tx_data[0].
REQ-021 In IDLE, sclk SHALL follow the live cpol input, registered.
REQ-022 SETUP SHALL last CLK_DIV cycles with sclk at the captured cpol, then enter XFER.
REQ-023 XFER SHALL toggle sclk every CLK_DIV cycles, exactly 2*DATA_W toggles, lasting 2*DATA_W*CLK_DIV cycles.
REQ-024 Bit timing by the captured cpha:
- cpha=0: sample miso on odd toggles (leading edges); advance mosi on even toggles, except after the last one.
- cpha=1: advance mosi on odd toggles, except the first (bit 0 is already driven); sample miso on even toggles.
REQ-025 Received bits SHALL be assembled in the same order as transmitted, per LSB_FIRST.
REQ-026 HOLD SHALL last CLK_DIV cycles with sclk at cpol and mosi held at the last bit.
REQ-027 At the end of HOLD, on the same edge: cs_n=1, rx_data updated, rx_valid=1 for exactly one cycle; then enter GAP.
REQ-028 GAP SHALL last CLK_DIV cycles with cs_n=1, then enter IDLE; busy=0 and tx_ready=1 from that edge.
REQ-029 cs_n SHALL be low for exactly CLK_DIV*(2*DATA_W+2) cycles per frame.
REQ-030 tx_ready SHALL be low for CLK_DIV*(2*DATA_W+3) cycles after acceptance.
REQ-031 tx_valid, tx_data, cpol and cpha changes while busy=1 SHALL be ignored and SHALL NOT affect the frame in flight.
REQ-032 With tx_valid held high, frames SHALL run back-to-back, accepting a new frame on each first IDLE cycle.
REQ-033 rx_data SHALL hold its value until the next frame completes.

Reset
REQ-034 While rst_n=0: state=IDLE, cs_n=1, sclk=0, mosi=0, rx_data=0, rx_valid=0, busy=0, tx_ready=1; all shift registers and counters cleared.
REQ-035 Reset asserted mid-frame SHALL abort immediately: cs_n=1 asynchronously and no rx_valid pulse for the aborted frame.
REQ-036 The first cycle after rst_n rises SHALL be able to accept a frame.

Verification
REQ-037 Mode 0, defaults, miso looped to mosi, tx_data=0xA5 -> 8 rising sclk edges, mosi sequence 1,0,1,0,0,1,0,1, cs_n low 36 cycles, rx_valid pulse with rx_data=0xA5.
REQ-038 Mode 3 (cpol=1, cpha=1), miso tied 1, tx_data=0x3C -> sclk idles high, 8 rising sample edges, rx_data=0xFF, tx_ready low 38 cycles.
REQ-039 LSB_FIRST=1, DATA_W=16, CLK_DIV=1, loopback, tx_data=0x8001 -> first mosi bit 1, cs_n low 34 cycles, rx_data=0x8001.
REQ-040 tx_valid held high with tx_data 0x11 then 0x22 -> two frames, cs_n high exactly 2 cycles between them, two rx_valid pulses with 0x11 then 0x22.
REQ-041 rst_n pulsed low at cycle 10 of a frame -> cs_n=1 at once, no rx_valid, tx_ready=1 on the first cycle after release, and the next frame completes correctly.
REQ-042 cpol toggled and tx_valid pulsed mid-frame -> current frame waveform unchanged and no second acceptance.
